// File: rtl/pergate_compute_gatefn_seqn.sv
// Per-gate evaluator: runs gate_fn(in0[k], in1[k]) for every point k
// through one shared computation_gatefn unit, one point at a time.

module computation_gatefn #(
  parameter int                     GATEFN_BITS = 1,
  parameter logic [GATEFN_BITS-1:0] gate_fn     = '0,
  parameter int                     F_NBITS     = 61
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               en,
  input  logic               mux_sel,
  input  logic [F_NBITS-1:0] in0,
  input  logic [F_NBITS-1:0] in1,
  output logic [F_NBITS-1:0] out,
  output logic               ready
);

  // Field modulus is the Mersenne prime 2^F_NBITS - 1.
  localparam logic [F_NBITS-1:0] P = '1;

  logic               r_busy;
  logic               r_sel;
  logic [F_NBITS-1:0] r_a;
  logic [F_NBITS-1:0] r_b;
  logic [F_NBITS-1:0] r_c;
  logic               w_mul;
  logic [F_NBITS-1:0] w_c;

  function automatic logic [F_NBITS-1:0] add_p(
    input logic [F_NBITS-1:0] a,
    input logic [F_NBITS-1:0] b
  );
    logic [F_NBITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[F_NBITS-1:0];
  endfunction

  function automatic logic [F_NBITS-1:0] mul_p(
    input logic [F_NBITS-1:0] a,
    input logic [F_NBITS-1:0] b
  );
    logic [2*F_NBITS-1:0] m;
    logic [F_NBITS:0]     s;
    m = {{F_NBITS{1'b0}}, a} * {{F_NBITS{1'b0}}, b};
    // 2^F_NBITS == 1 mod P, so fold the high half onto the low half
    s = {1'b0, m[F_NBITS-1:0]} + {1'b0, m[2*F_NBITS-1:F_NBITS]};
    s = {1'b0, s[F_NBITS-1:0]} + {{F_NBITS{1'b0}}, s[F_NBITS]};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[F_NBITS-1:0];
  endfunction

  // mux_sel swaps to the alternate gate (add <-> mul)
  assign w_mul = gate_fn[0] ^ r_sel;

  // Field op on the latched operands
  always_comb begin
    w_c = add_p(r_a, r_b);
    if (w_mul) w_c = mul_p(r_a, r_b);
  end

  // Latch operands on en, produce the result one cycle later
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_busy <= 1'b0;
      r_sel  <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= '0;
    end else if (r_busy) begin
      r_c    <= w_c;
      r_busy <= 1'b0;
    end else if (en) begin
      r_a    <= in0;
      r_b    <= in1;
      r_sel  <= mux_sel;
      r_busy <= 1'b1;
    end
  end

  assign ready = ~r_busy & ~en;
  assign out   = r_c;

endmodule

module pergate_compute_gatefn_seqn #(
  parameter int                     GATEFN_BITS = 1,
  parameter logic [GATEFN_BITS-1:0] gate_fn     = '0,
  parameter int                     npoints     = 3,
  parameter int                     F_NBITS     = 61
) (
  input  logic                            clk,
  input  logic                            rstb,
  input  logic                            en,
  input  logic                            mux_sel,
  input  logic [npoints-1:0][F_NBITS-1:0] in0,
  input  logic [npoints-1:0][F_NBITS-1:0] in1,
  output logic                            ready,
  output logic                            ready_pulse,
  output logic [npoints-1:0][F_NBITS-1:0] gatefn
);

  localparam int IW = (npoints > 1) ? $clog2(npoints) : 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  logic               r_en_fn;
  logic [IW-1:0]      w_idx;
  logic               w_last;
  logic               w_adv;
  logic               w_fn_ready;
  logic [F_NBITS-1:0] w_fn_a;
  logic [F_NBITS-1:0] w_fn_b;
  logic [F_NBITS-1:0] w_fn_c;
  logic [npoints-1:0] w_we;

  assign w_adv = (r_state == ST_RUN) && w_fn_ready;

  if (npoints == 1) begin : g_one
    assign w_idx  = '0;
    assign w_last = 1'b1;
  end else begin : g_many
    localparam logic [IW-1:0] LAST = IW'(npoints - 1);
    logic [IW-1:0] r_idx;

    // Point counter: advances per accepted result, wraps to 0 at the end
    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
        r_idx <= '0;
      end else if (r_state != ST_RUN) begin
        r_idx <= '0;
      end else if (w_adv) begin
        r_idx <= w_last ? '0 : r_idx + IW'(1);
      end
    end

    assign w_idx  = r_idx;
    assign w_last = (r_idx == LAST);
  end

  // Operand mux for the current point; don't-care while idle
  always_comb begin
    w_fn_a = 'x;
    w_fn_b = 'x;
    if (r_state == ST_RUN) begin
      for (int k = 0; k < npoints; k++) begin
        if (w_idx == IW'(k)) begin
          w_fn_a = in0[k];
          w_fn_b = in1[k];
        end
      end
    end
  end

  // One-hot write enable for the result slot of the current point
  always_comb begin
    w_we = '0;
    for (int k = 0; k < npoints; k++) begin
      w_we[k] = w_adv && (w_idx == IW'(k));
    end
  end

  // Result registers, updated in place one point at a time
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      gatefn <= '0;
    end else begin
      for (int k = 0; k < npoints; k++) begin
        if (w_we[k]) gatefn[k] <= w_fn_c;
      end
    end
  end

  // Sequencer: launch each point, finish with a one-cycle ready_pulse
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state     <= ST_IDLE;
      r_en_fn     <= 1'b0;
      ready_pulse <= 1'b0;
    end else begin
      r_en_fn     <= 1'b0;
      ready_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (en) begin
            r_en_fn <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_fn_ready) begin
            if (w_last) begin
              r_state     <= ST_IDLE;
              ready_pulse <= 1'b1;
            end else begin
              r_en_fn <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ready = (r_state == ST_IDLE) & ~en;

  computation_gatefn #(
    .GATEFN_BITS (GATEFN_BITS),
    .gate_fn     (gate_fn),
    .F_NBITS     (F_NBITS)
  ) u_fn (
    .clk     (clk),
    .rstb    (rstb),
    .en      (r_en_fn),
    .mux_sel (mux_sel),
    .in0     (w_fn_a),
    .in1     (w_fn_b),
    .out     (w_fn_c),
    .ready   (w_fn_ready)
  );

endmodule

// File: tb/tb_pergate_compute_gatefn_seqn.sv
// Directed bench for pergate_compute_gatefn_seqn: add x3, mul x5
// and a single-point instance sharing one clock and reset.

module tb_pergate_compute_gatefn_seqn;

  localparam int FW = 61;
  localparam logic [FW-1:0] PM1 = {{(FW-1){1'b1}}, 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rstb;
  logic [2:0]           en;
  logic [2:0]           rdy;
  logic [2:0]           rp;
  logic                 sel_c;
  logic [2:0][FW-1:0]   a0, a1, ag;
  logic [4:0][FW-1:0]   b0, b1, bg;
  logic [0:0][FW-1:0]   c0, c1, cg;

  int n_run  = 0;
  int n_fail = 0;

  pergate_compute_gatefn_seqn #(
    .gate_fn (1'b0), .npoints (3), .F_NBITS (FW)
  ) u_add3 (
    .clk (clk), .rstb (rstb), .en (en[0]), .mux_sel (1'b0),
    .in0 (a0), .in1 (a1), .ready (rdy[0]),
    .ready_pulse (rp[0]), .gatefn (ag)
  );

  pergate_compute_gatefn_seqn #(
    .gate_fn (1'b1), .npoints (5), .F_NBITS (FW)
  ) u_mul5 (
    .clk (clk), .rstb (rstb), .en (en[1]), .mux_sel (1'b0),
    .in0 (b0), .in1 (b1), .ready (rdy[1]),
    .ready_pulse (rp[1]), .gatefn (bg)
  );

  pergate_compute_gatefn_seqn #(
    .gate_fn (1'b0), .npoints (1), .F_NBITS (FW)
  ) u_add1 (
    .clk (clk), .rstb (rstb), .en (en[2]), .mux_sel (sel_c),
    .in0 (c0), .in1 (c1), .ready (rdy[2]),
    .ready_pulse (rp[2]), .gatefn (cg)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle en pulse; returns at the negedge after the sampling edge
  task automatic start(input int i);
    en[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en[i] = 1'b0;
  endtask

  // Count edges until ready_pulse; a timeout shows up as a wrong count
  task automatic wait_pulse(input int i, input int exp_n,
                            input string tag);
    int  n    = 0;
    bit  seen = 1'b0;
    while (!seen && n < 60) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      seen = rp[i];
    end
    chk({tag, "_lat"}, 64'(n), 64'(exp_n));
  endtask

  initial begin
    int extra;
    rstb  = 1'b0;
    en    = '0;
    sel_c = 1'b0;
    a0 = {61'd3, 61'd2, 61'd1};
    a1 = {61'd6, 61'd5, 61'd4};
    b0 = {61'd6, 61'd5, 61'd4, 61'd3, 61'd2};
    b1 = {5{61'd3}};
    c0 = 61'd7;
    c1 = 61'd8;

    repeat (2) @(negedge clk);
    chk("rst_ag0", 64'(ag[0]), 64'd0);
    chk("rst_bg4", 64'(bg[4]), 64'd0);
    chk("rst_rdy", 64'(rdy), 64'b111);
    chk("rst_rp", 64'(rp), 64'b000);
    rstb = 1'b1;
    @(negedge clk);

    // ready drops combinationally with en
    en[0] = 1'b1;
    #1 chk("rdy_en_low", 64'(rdy[0]), 64'd0);
    @(posedge clk);
    @(negedge clk);
    en[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("pt0_written", 64'(ag[0]), 64'd5);
    chk("busy_rdy", 64'(rdy[0]), 64'd0);

    // Abort mid-run with reset
    rstb = 1'b0;
    #1;
    chk("abort_ag0", 64'(ag[0]), 64'd0);
    chk("abort_ag1", 64'(ag[1]), 64'd0);
    chk("abort_rdy", 64'(rdy[0]), 64'd1);
    chk("abort_rp", 64'(rp[0]), 64'd0);
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", 64'(rdy[0]), 64'd1);

    // Full add run after the abort
    start(0);
    wait_pulse(0, 9, "add3");
    chk("add3_g0", 64'(ag[0]), 64'd5);
    chk("add3_g1", 64'(ag[1]), 64'd7);
    chk("add3_g2", 64'(ag[2]), 64'd9);
    @(negedge clk);
    chk("add3_rp_1cyc", 64'(rp[0]), 64'd0);
    chk("add3_rdy", 64'(rdy[0]), 64'd1);

    // Busy en at point 1 is ignored
    a0 = {61'd30, 61'd20, 61'd10};
    a1 = {3{61'd1}};
    start(0);
    repeat (3) @(negedge clk);
    en[0] = 1'b1;
    @(negedge clk);
    en[0] = 1'b0;
    wait_pulse(0, 5, "busy_en");
    chk("busy_g0", 64'(ag[0]), 64'd11);
    chk("busy_g1", 64'(ag[1]), 64'd21);
    chk("busy_g2", 64'(ag[2]), 64'd31);
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      extra += int'(rp[0]);
    end
    chk("busy_no_2nd_pulse", 64'(extra), 64'd0);

    // Mul x5, then back-to-back with p-1 operands
    start(1);
    wait_pulse(1, 15, "mul5");
    for (int k = 0; k < 5; k++)
      chk($sformatf("mul5_g%0d", k), 64'(bg[k]), 64'(3 * (k + 2)));
    b0 = {5{PM1}};
    b1 = {5{PM1}};
    start(1);
    repeat (3) @(negedge clk);
    chk("b2b_g0_new", 64'(bg[0]), 64'd1);
    chk("b2b_g1_old", 64'(bg[1]), 64'd9);
    chk("b2b_g4_old", 64'(bg[4]), 64'd18);
    wait_pulse(1, 12, "b2b");
    for (int k = 0; k < 5; k++)
      chk($sformatf("wrap_g%0d", k), 64'(bg[k]), 64'd1);

    // Single point: add, then alternate gate via mux_sel
    start(2);
    wait_pulse(2, 3, "one_add");
    chk("one_add_g0", 64'(cg[0]), 64'd15);
    sel_c = 1'b1;
    start(2);
    wait_pulse(2, 3, "one_mux");
    chk("one_mux_g0", 64'(cg[0]), 64'd56);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
